fb_if_id: RTL
=============

Name: fb_if_id

Overview:
- IF/ID pipeline register directly downstream of the PC stage.
- Captures the fetched instruction and its PC each cycle and presents them to decode.
- Honours data-hazard hold and branch flush.
- Enforces the one-cycle jalr lock by turning the slot after a captured jalr into a NOP bubble, so two consecutive jalr never reach decode.
- Keeps a saturating bubble counter for debug and performance visibility.

Parameters:
- ADDR_W, 32, width of PC / address path (word-addressed, +1 per instruction).
- INST_W, 32, instruction width.
- NOP_INST, 32'h00000013, encoding inserted on bubble/flush (addi x0,x0,0).
- CNT_W, 16, width of bubble counter.

Ports:
- clk  in  1  rising-edge clock.
- ifid_reset_n  in  1  synchronous, active-low reset.
- in_pc  in  ADDR_W  PC of the instruction being fetched (from PC stage out_address).
- in_inst  in  INST_W  instruction read from ROM at in_pc, valid in the same cycle.
- in_clear  in  1  clear request from PC stage (its clear_inst); forces a bubble.
- ifid_hold  in  1  1 = hazard stall, hold all outputs (same polarity as the PC stage pc_write).
- ifid_flush  in  1  1 = taken branch/jump redirect, discard the captured instruction.
- out_pc  out  ADDR_W  registered PC of the decode-stage instruction.
- out_pc_next  out  ADDR_W  registered out_pc + 1, modulo 2^ADDR_W.
- out_inst  out  INST_W  registered instruction, NOP_INST when invalid.
- out_valid  out  1  1 = out_inst is a real fetched instruction.
- jalr_lock  out  1  1 while the FSM is in LOCK.
- bubble_cnt  out  CNT_W  count of bubbles inserted since reset.

Behaviour:
- Reset (ifid_reset_n=0 at posedge):
  - out_pc=0, out_pc_next=1, out_inst=NOP_INST, out_valid=0.
  - FSM=RUN, jalr_lock=0, bubble_cnt=0.
  - Reset overrides every other input, including mid-LOCK.
- FSM states are RUN and LOCK. jalr_lock is a registered decode of state==LOCK.
- Update priority at each posedge (after reset): flush > hold > LOCK > in_clear > normal capture.
- Flush:
  - out_inst=NOP_INST, out_valid=0, out_pc=in_pc, out_pc_next=in_pc+1.
  - FSM→RUN, bubble_cnt+1.
  - Flush wins over a simultaneous hold.
- Hold (no flush): all outputs, FSM state and bubble_cnt are unchanged. A hold while in LOCK extends LOCK until the first non-hold cycle.
- LOCK (no flush, no hold): out_inst=NOP_INST, out_valid=0, out_pc/out_pc_next take in_pc/in_pc+1, FSM→RUN, bubble_cnt+1. LOCK always lasts exactly one effective (non-held) cycle.
- in_clear in RUN (no flush, no hold): same as a LOCK bubble, but the FSM stays RUN.
- Normal capture in RUN:
  - out_inst=in_inst, out_valid=1, out_pc=in_pc, out_pc_next=in_pc+1.
  - If in_inst[6:0]==7'b1100111 (jalr), FSM→LOCK.
- Only a valid captured jalr enters LOCK. A jalr presented while in LOCK, or during flush or clear, is discarded and does not re-arm LOCK.
- bubble_cnt saturates at all-ones and never wraps.
- out_pc_next wraps modulo 2^ADDR_W: in_pc = all-ones gives 0.
- Latency: exactly one cycle from in_pc/in_inst to out_*. No combinational path from inputs to outputs.

Test Plan:
- Reset then 4 free-running cycles with in_pc=0,1,2,3 and non-jalr instructions → out_pc follows one cycle later: 0,1,2,3; out_valid=1; bubble_cnt=0.
- Capture jalr 32'h000080E7 at in_pc=5, then present 32'h00A00093 at in_pc=6 → cycle+1 shows jalr valid; cycle+2 shows out_inst=32'h00000013, out_valid=0, jalr_lock=1 on the prior cycle; bubble_cnt=1.
- Back-to-back jalr at in_pc=5 and 6 → only the first appears valid; the second becomes a bubble; the FSM returns to RUN.
- Hold asserted for 3 cycles during LOCK → outputs are frozen and jalr_lock stays 1; the bubble is inserted on the first non-hold cycle; bubble_cnt increments once.
- Flush and hold asserted together with in_pc=0x40 → out_pc=0x40, out_inst=NOP_INST, out_valid=0, bubble_cnt+1.
- Reset pulse while in LOCK → all outputs return to reset values and the next capture is a normal valid instruction. Separately, preload to saturation with CNT_W=4: 20 flushes → bubble_cnt=15; in_pc=32'hFFFFFFFF → out_pc_next=0.

Source files
------------

// File: rtl/fb_if_id.sv
// IF/ID pipeline register: captures PC and instruction for decode, honouring
// hold/flush, and inserts a one-cycle bubble after every captured jalr.
module fb_if_id #(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter logic [INST_W-1:0] NOP_INST = INST_W'(32'h00000013),
  parameter int                CNT_W    = 16
) (
  input  logic              clk,
  input  logic              ifid_reset_n,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic [INST_W-1:0] in_inst,
  input  logic              in_clear,
  input  logic              ifid_hold,
  input  logic              ifid_flush,
  output logic [ADDR_W-1:0] out_pc,
  output logic [ADDR_W-1:0] out_pc_next,
  output logic [INST_W-1:0] out_inst,
  output logic              out_valid,
  output logic              jalr_lock,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef enum logic {RUN = 1'b0, LOCK = 1'b1} state_t;

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_jalr_lock;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_pc_next;
  logic [INST_W-1:0] r_inst;
  logic              r_valid;
  logic [CNT_W-1:0]  r_bubble_cnt;

  logic              w_is_jalr;
  logic              w_load;
  logic              w_capture;
  logic              w_bubble;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  assign w_is_jalr = (in_inst[6:0] == 7'b1100111);

  always_ff @(posedge clk) begin
    if (!ifid_reset_n) begin
      r_state     <= RUN;
      r_jalr_lock <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_jalr_lock <= (w_state_nxt == LOCK);
    end
  end

  // Priority: flush > hold > LOCK > clear > capture; only a captured jalr arms LOCK.
  always_comb begin
    w_state_nxt = r_state;
    if (ifid_flush)           w_state_nxt = RUN;
    else if (ifid_hold)       w_state_nxt = r_state;
    else if (r_state == LOCK) w_state_nxt = RUN;
    else if (in_clear)        w_state_nxt = RUN;
    else if (w_is_jalr)       w_state_nxt = LOCK;
  end

  always_comb begin
    w_load    = ifid_flush | ~ifid_hold;
    w_capture = ~ifid_flush & ~ifid_hold & (r_state == RUN) & ~in_clear;
    w_bubble  = w_load & ~w_capture;
  end

  always_ff @(posedge clk) begin
    if (!ifid_reset_n) begin
      r_pc         <= '0;
      r_pc_next    <= PC_ONE;
      r_inst       <= NOP_INST;
      r_valid      <= 1'b0;
      r_bubble_cnt <= '0;
    end else begin
      if (w_load) begin
        r_pc      <= in_pc;
        r_pc_next <= in_pc + PC_ONE;
        r_inst    <= w_capture ? in_inst : NOP_INST;
        r_valid   <= w_capture;
      end
      if (w_bubble) r_bubble_cnt <= sat_inc(r_bubble_cnt);
    end
  end

  assign out_pc      = r_pc;
  assign out_pc_next = r_pc_next;
  assign out_inst    = r_inst;
  assign out_valid   = r_valid;
  assign jalr_lock   = r_jalr_lock;
  assign bubble_cnt  = r_bubble_cnt;

endmodule
